move_arbiter: RTL and testbench

- Owns both player position registers.
- Shares the single combinational collision checker between two players through a round-robin arbiter.
- Sequences each move: grant, drive checker, wait CHK_LAT cycles, commit result, acknowledge.
- Applies a per-player move cooldown. Sits between input decode and the collision checker/renderer.

---
 rtl/move_pkg.sv | 29 ++
 rtl/move_arbiter_rr_arb2.sv | 20 ++
 rtl/move_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_move_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_pkg.sv
// Shared types and constants for the two-player move arbiter: direction codes,
// sequencer states, position/map widths and cooldown helpers.
package move_pkg;

    localparam int POS_W = 6;
    localparam int MAP_W = 3;
    localparam int CD_W  = 8;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // The DONE cycle is the first cooldown cycle, so the counter starts one short.
    function automatic logic [CD_W-1:0] cd_load(input int cooldown);
        return (cooldown > 0) ? CD_W'(cooldown - 1) : '0;
    endfunction

    function automatic logic [CD_W-1:0] cd_step(input logic [CD_W-1:0] cd);
        return (cd == '0) ? cd : cd - 1'b1;
    endfunction

endpackage

// File: rtl/move_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: on a tie the requester that did not win
// last time is granted.
module rr_arb2 (
    input  logic [1:0] elig,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |elig;
        grant_id    = 1'b0;
        case (elig)
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/move_arbiter.sv
// Owns both player positions and time-shares the collision checker between them.
// Optional build macro RESPAWN_ON_MAP_EN: a map change sends both players to spawn.
module move_arbiter
    import move_pkg::*;
#(
    parameter int CHK_LAT  = 1,
    parameter int COOLDOWN = 4,
    parameter int P0_X0    = 1,
    parameter int P0_Y0    = 1,
    parameter int P1_X0    = 18,
    parameter int P1_Y0    = 13
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [MAP_W-1:0] map_sel,
    input  logic [1:0]       p_req,
    input  logic [1:0]       p0_move,
    input  logic [1:0]       p1_move,
    output logic [1:0]       p_ack,
    output logic [1:0]       p_bump,
    output logic [POS_W-1:0] p0_x,
    output logic [POS_W-1:0] p0_y,
    output logic [POS_W-1:0] p1_x,
    output logic [POS_W-1:0] p1_y,
    output logic [POS_W-1:0] chk_x,
    output logic [POS_W-1:0] chk_y,
    output logic [1:0]       chk_move,
    output logic [MAP_W-1:0] chk_map,
    input  logic [POS_W-1:0] chk_new_x,
    input  logic [POS_W-1:0] chk_new_y,
    output logic             busy
);

    localparam int CNT_W = (CHK_LAT < 2) ? 1 : $clog2(CHK_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CHK_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CD_W-1:0]  CD_LOAD  = cd_load(COOLDOWN);
    localparam logic [POS_W-1:0] S0_X = POS_W'(P0_X0);
    localparam logic [POS_W-1:0] S0_Y = POS_W'(P0_Y0);
    localparam logic [POS_W-1:0] S1_X = POS_W'(P1_X0);
    localparam logic [POS_W-1:0] S1_Y = POS_W'(P1_Y0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             gid_q;
    logic             last_q;
    logic [CD_W-1:0]  cd_q [2];
    logic [POS_W-1:0] pos_x_q [2];
    logic [POS_W-1:0] pos_y_q [2];

    logic [1:0] elig;
    logic       arb_valid;
    logic       arb_id;
    logic       do_grant;
    logic       do_commit;
    logic       do_respawn;
    logic       respawn_idle;
    logic       respawn_commit;
    logic       same_pos;

    assign elig[0] = p_req[0] && (cd_q[0] == '0);
    assign elig[1] = p_req[1] && (cd_q[1] == '0);

    rr_arb2 u_arb (
        .elig        (elig),
        .last_grant  (last_q),
        .grant_valid (arb_valid),
        .grant_id    (arb_id)
    );

`ifdef RESPAWN_ON_MAP_EN
    logic [MAP_W-1:0] map_q;
    logic             pend_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            map_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            map_q <= map_sel;
            if (do_respawn)
                pend_q <= 1'b0;
            else if (map_sel != map_q)
                pend_q <= 1'b1;
        end
    end

    assign respawn_idle   = pend_q;
    // A change landing on the commit edge itself must also discard the result.
    assign respawn_commit = pend_q || (map_sel != map_q);
`else
    assign respawn_idle   = 1'b0;
    assign respawn_commit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        do_grant   = 1'b0;
        do_commit  = 1'b0;
        do_respawn = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (respawn_idle) begin
                    do_respawn = 1'b1;
                end else if (arb_valid) begin
                    do_grant = 1'b1;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_ONE) begin
                    do_commit  = 1'b1;
                    do_respawn = respawn_commit;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign same_pos = (chk_new_x == chk_x) && (chk_new_y == chk_y);

    // Grant capture, latency count, acknowledge and cooldown bookkeeping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            gid_q    <= 1'b0;
            last_q   <= 1'b1;
            cd_q[0]  <= '0;
            cd_q[1]  <= '0;
            chk_x    <= '0;
            chk_y    <= '0;
            chk_move <= '0;
            chk_map  <= '0;
            p_ack    <= '0;
            p_bump   <= '0;
        end else begin
            p_ack   <= '0;
            p_bump  <= '0;
            cd_q[0] <= cd_step(cd_q[0]);
            cd_q[1] <= cd_step(cd_q[1]);

            if (do_grant) begin
                gid_q    <= arb_id;
                chk_x    <= pos_x_q[arb_id];
                chk_y    <= pos_y_q[arb_id];
                chk_move <= arb_id ? p1_move : p0_move;
                chk_map  <= map_sel;
                cnt_q    <= CNT_LOAD;
            end else if (state_q == ST_DRIVE) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (do_commit) begin
                p_ack[gid_q]  <= 1'b1;
                p_bump[gid_q] <= same_pos && !do_respawn;
                last_q        <= gid_q;
                cd_q[gid_q]   <= CD_LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pos_x_q[0] <= S0_X;
            pos_y_q[0] <= S0_Y;
            pos_x_q[1] <= S1_X;
            pos_y_q[1] <= S1_Y;
        end else if (do_respawn) begin
            pos_x_q[0] <= S0_X;
            pos_y_q[0] <= S0_Y;
            pos_x_q[1] <= S1_X;
            pos_y_q[1] <= S1_Y;
        end else if (do_commit) begin
            pos_x_q[gid_q] <= chk_new_x;
            pos_y_q[gid_q] <= chk_new_y;
        end
    end

    assign p0_x = pos_x_q[0];
    assign p0_y = pos_y_q[0];
    assign p1_x = pos_x_q[1];
    assign p1_y = pos_y_q[1];

endmodule

// File: tb/tb_move_arbiter.sv
// Bench for move_arbiter: directed move table, multi-cycle corner sequences and
// a randomized run against a transaction-timing reference model.
module tb_move_arbiter;
    import move_pkg::*;

    localparam int L  = 1;
    localparam int CD = 4;
    localparam int GAP = L + ((CD > 2) ? CD : 2);

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] map_sel = '0;
    logic [1:0] p_req = '0;
    logic [1:0] p0_move = '0;
    logic [1:0] p1_move = '0;
    logic [1:0] p_ack, p_bump;
    logic [5:0] p0_x, p0_y, p1_x, p1_y, chk_x, chk_y, chk_new_x, chk_new_y;
    logic [1:0] chk_move;
    logic [2:0] chk_map;
    logic       busy;

    int checks = 0;
    int failures = 0;

    move_arbiter #(
        .CHK_LAT(L), .COOLDOWN(CD),
        .P0_X0(1), .P0_Y0(1), .P1_X0(18), .P1_Y0(13)
    ) dut (
        .clk(clk), .resetn(resetn), .map_sel(map_sel), .p_req(p_req),
        .p0_move(p0_move), .p1_move(p1_move), .p_ack(p_ack), .p_bump(p_bump),
        .p0_x(p0_x), .p0_y(p0_y), .p1_x(p1_x), .p1_y(p1_y),
        .chk_x(chk_x), .chk_y(chk_y), .chk_move(chk_move), .chk_map(chk_map),
        .chk_new_x(chk_new_x), .chk_new_y(chk_new_y), .busy(busy)
    );

    always #5 clk = ~clk;

    // Playfield: x 1..18, y 1..13, plus a wall column at x=4+map for y<=6.
    function automatic logic [11:0] chk_fn(input logic [5:0] x, input logic [5:0] y,
                                           input logic [1:0] mv, input logic [2:0] mp);
        int nx, ny;
        nx = int'(x);
        ny = int'(y);
        case (mv)
            DIR_UP:   ny = ny - 1;
            DIR_LEFT: nx = nx - 1;
            DIR_DOWN: ny = ny + 1;
            default:  nx = nx + 1;
        endcase
        if (nx < 1 || nx > 18 || ny < 1 || ny > 13 || (nx == 4 + int'(mp) && ny <= 6))
            return {x, y};
        return {6'(nx), 6'(ny)};
    endfunction

    always_comb {chk_new_x, chk_new_y} = chk_fn(chk_x, chk_y, chk_move, chk_map);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        p_req  = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    typedef struct {
        int         pl;
        logic [1:0] mv;
        int         ex;
        int         ey;
        bit         eb;
    } vec_t;

    task automatic do_move(input vec_t v);
        int  rise;
        int  tk;
        bit  seen;
        logic prev;
        if (v.pl == 0) p0_move = v.mv; else p1_move = v.mv;
        p_req[v.pl] = 1'b1;
        rise = -100;
        seen = 1'b0;
        tk   = 0;
        prev = busy;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk);
            #1;
            if (busy && !prev) rise = t;
            prev = busy;
            if (p_ack[v.pl]) begin
                seen = 1'b1;
                tk   = t;
                break;
            end
        end
        check("vec_ack_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("vec_ack_latency", 32'(tk - rise), 32'(L));
            check("vec_bump", 32'(p_bump[v.pl]), 32'(v.eb));
            if (v.pl == 0) check("vec_pos", {20'd0, p0_x, p0_y}, {20'd0, 6'(v.ex), 6'(v.ey)});
            else           check("vec_pos", {20'd0, p1_x, p1_y}, {20'd0, 6'(v.ex), 6'(v.ey)});
        end
        p_req[v.pl] = 1'b0;
        @(posedge clk);
        #1;
        check("vec_ack_width", 32'(p_ack), 32'd0);
    endtask

    // Reference model: transactions described by edge times, not by FSM states.
    int   m_px[2], m_py[2], ready[2];
    int   free_e, last_g, g, g_e, c_e, nx, ny;
    bit   infl, nb;
    logic [1:0] e_ack, e_bump;
    bit   e_busy;
    logic [5:0] e_cx, e_cy;
    logic [1:0] e_cm;
    logic [2:0] e_cmap;

    task automatic model_init();
        m_px[0] = 1;  m_py[0] = 1;
        m_px[1] = 18; m_py[1] = 13;
        ready[0] = 0; ready[1] = 0;
        free_e = 0; last_g = 1; infl = 0;
        g = 0; g_e = -10; c_e = -10;
        e_cx = '0; e_cy = '0; e_cm = '0; e_cmap = '0;
    endtask

    task automatic model_edge(input int n);
        bit el0, el1;
        logic [11:0] r;
        logic [1:0] mv;
        e_ack  = '0;
        e_bump = '0;
        if (infl && n == c_e) begin
            m_px[g] = nx; m_py[g] = ny;
            e_ack[g] = 1'b1;
            e_bump[g] = nb;
            last_g = g;
            ready[g] = n + CD;
            free_e = n + 2;
            infl = 0;
        end else if (!infl && n >= free_e) begin
            el0 = p_req[0] && n >= ready[0];
            el1 = p_req[1] && n >= ready[1];
            if (el0 || el1) begin
                if (el0 && el1) g = 1 - last_g;
                else            g = el1 ? 1 : 0;
                mv = (g == 1) ? p1_move : p0_move;
                r = chk_fn(6'(m_px[g]), 6'(m_py[g]), mv, map_sel);
                nx = int'(r[11:6]);
                ny = int'(r[5:0]);
                nb = (nx == m_px[g]) && (ny == m_py[g]);
                e_cx = 6'(m_px[g]); e_cy = 6'(m_py[g]);
                e_cm = mv; e_cmap = map_sel;
                g_e = n; c_e = n + L;
                infl = 1;
            end
        end
        e_busy = (n >= g_e) && (n <= c_e);
    endtask

    vec_t vecs[9];

    initial begin
        int at[3];
        int na;
        int ids[3];
        bit seen;
        bit anyack;

        vecs[0] = '{0, DIR_UP,    1,  1,  1'b1};
        vecs[1] = '{0, DIR_RIGHT, 2,  1,  1'b0};
        vecs[2] = '{0, DIR_RIGHT, 3,  1,  1'b0};
        vecs[3] = '{0, DIR_RIGHT, 3,  1,  1'b1};
        vecs[4] = '{0, DIR_DOWN,  3,  2,  1'b0};
        vecs[5] = '{1, DIR_RIGHT, 18, 13, 1'b1};
        vecs[6] = '{1, DIR_DOWN,  18, 13, 1'b1};
        vecs[7] = '{1, DIR_LEFT,  17, 13, 1'b0};
        vecs[8] = '{1, DIR_UP,    17, 12, 1'b0};

        // Reset state
        do_reset();
        check("rst_p0", {20'd0, p0_x, p0_y}, {20'd0, 6'd1, 6'd1});
        check("rst_p1", {20'd0, p1_x, p1_y}, {20'd0, 6'd18, 6'd13});
        check("rst_ack_bump", {28'd0, p_ack, p_bump}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_chk", {15'd0, chk_x, chk_y, chk_move, chk_map}, 32'd0);

        // Directed move table
        for (int i = 0; i < 9; i++) do_move(vecs[i]);

        // Cooldown: p0 holds its request, acks are spaced by latency plus cooldown
        p0_move = DIR_LEFT;
        p_req[0] = 1'b1;
        na = 0;
        for (int t = 0; t < 80 && na < 3; t++) begin
            @(posedge clk);
            #1;
            if (p_ack[0]) begin
                at[na] = t;
                na++;
            end
        end
        p_req[0] = 1'b0;
        check("cd_ack_count", 32'(na), 32'd3);
        if (na == 3) begin
            check("cd_gap1", 32'(at[1] - at[0]), 32'(GAP));
            check("cd_gap2", 32'(at[2] - at[1]), 32'(GAP));
        end
        check("cd_final_pos", {20'd0, p0_x, p0_y}, {20'd0, 6'd1, 6'd2});
        repeat (8) @(posedge clk);

        // Contention from reset: P0 wins the first tie, then alternation
        do_reset();
        p0_move = DIR_RIGHT;
        p1_move = DIR_LEFT;
        p_req = 2'b11;
        na = 0;
        for (int t = 0; t < 80 && na < 3; t++) begin
            @(posedge clk);
            #1;
            if (p_ack != 2'b00) begin
                ids[na] = p_ack[1] ? 1 : 0;
                na++;
            end
        end
        p_req = '0;
        check("cont_ack_count", 32'(na), 32'd3);
        if (na == 3) begin
            check("cont_grant0", 32'(ids[0]), 32'd0);
            check("cont_grant1", 32'(ids[1]), 32'd1);
            check("cont_grant2", 32'(ids[2]), 32'd0);
        end

        // Reset asserted while the checker is being driven
        do_reset();
        p0_move = DIR_RIGHT;
        p_req[0] = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("midrst_busy_seen", 32'(seen), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_p0", {20'd0, p0_x, p0_y}, {20'd0, 6'd1, 6'd1});
        check("midrst_ack_busy", {29'd0, p_ack, busy}, 32'd0);
        p_req = '0;
        @(negedge clk);
        resetn = 1'b1;
        anyack = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (p_ack != 2'b00) anyack = 1'b1;
        end
        check("midrst_no_ack", 32'(anyack), 32'd0);
        check("midrst_p0_after", {20'd0, p0_x, p0_y}, {20'd0, 6'd1, 6'd1});

`ifdef RESPAWN_ON_MAP_EN
        do_reset();
        do_move('{0, DIR_RIGHT, 2, 1, 1'b0});
        p0_move = DIR_RIGHT;
        p_req[0] = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        map_sel = 3'd1;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk);
            #1;
            if (p_ack[0]) begin
                seen = 1'b1;
                break;
            end
        end
        p_req = '0;
        check("resp_ack", 32'(seen), 32'd1);
        check("resp_bump", 32'(p_bump), 32'd0);
        check("resp_p0", {20'd0, p0_x, p0_y}, {20'd0, 6'd1, 6'd1});
        check("resp_p1", {20'd0, p1_x, p1_y}, {20'd0, 6'd18, 6'd13});
        map_sel = 3'd0;
        repeat (4) @(posedge clk);
`endif

        // Randomized run against the reference model
        map_sel = 3'd0;
        do_reset();
        model_init();
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            model_edge(n);
            #1;
            check("rnd_ack", 32'(p_ack), 32'(e_ack));
            check("rnd_bump", 32'(p_bump), 32'(e_bump));
            check("rnd_busy", 32'(busy), 32'(e_busy));
            check("rnd_p0", {20'd0, p0_x, p0_y}, {20'd0, 6'(m_px[0]), 6'(m_py[0])});
            check("rnd_p1", {20'd0, p1_x, p1_y}, {20'd0, 6'(m_px[1]), 6'(m_py[1])});
            check("rnd_chk", {15'd0, chk_x, chk_y, chk_move, chk_map},
                  {15'd0, e_cx, e_cy, e_cm, e_cmap});
            for (int i = 0; i < 2; i++) begin
                if (p_ack[i]) begin
                    p_req[i] = 1'($urandom_range(0, 1));
                    if (i == 0) p0_move = 2'($urandom_range(0, 3));
                    else        p1_move = 2'($urandom_range(0, 3));
                end else if (p_req[i]) begin
                    int r;
                    r = int'($urandom_range(0, 99));
                    if (r < 4) p_req[i] = 1'b0;
                    else if (r < 12) begin
                        if (i == 0) p0_move = 2'($urandom_range(0, 3));
                        else        p1_move = 2'($urandom_range(0, 3));
                    end
                end else if ($urandom_range(0, 99) < 30) begin
                    p_req[i] = 1'b1;
                    if (i == 0) p0_move = 2'($urandom_range(0, 3));
                    else        p1_move = 2'($urandom_range(0, 3));
                end
            end
`ifndef RESPAWN_ON_MAP_EN
            if ($urandom_range(0, 99) < 3) map_sel = 3'($urandom_range(0, 7));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
